// File: rtl/pe_mac_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pe_mac_sequencer_pkg
//   Shared definitions for the MAC processing-element sequencer:
//   default datapath widths, drain timing and the FSM state encoding.
//   Imported by the interface, the round/saturate stage and the top level.
// ---------------------------------------------------------------------------
package pe_mac_sequencer_pkg;

  // Default widths: Q8.8 operands/results, Q16.16 accumulator.
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAC_BITS  = 8;
  localparam int DEF_LEN_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  // The PE needs two cycles after its last enable for acc_out to hold the
  // full sum; the third drain cycle samples it into the result register.
  localparam int DRAIN_CYCLES = 3;
  localparam int DRAIN_CNT_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/pe_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// pe_mac_sequencer_if
//   Bundles every non-clock signal of the sequencer:
//     cmd_*        command from the NPU scheduler (valid/ready)
//     act_*/wgt_*  operand buffer read strobes and addresses
//     pe_*         PE enable / accumulator clear / registered acc_out
//     res_*        Q8.8 result back to the scheduler (valid/ready)
//     busy         sequencer not idle
//   master: the sequencer's view.  slave: the environment's view.
// ---------------------------------------------------------------------------
interface pe_mac_sequencer_if #(
  parameter int DATA_WIDTH = pe_mac_sequencer_pkg::DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = pe_mac_sequencer_pkg::DEF_LEN_WIDTH,
  parameter int ADDR_WIDTH = pe_mac_sequencer_pkg::DEF_ADDR_WIDTH
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic [ADDR_WIDTH-1:0]   cmd_act_base;
  logic [ADDR_WIDTH-1:0]   cmd_wgt_base;

  logic                    act_rd_en;
  logic [ADDR_WIDTH-1:0]   act_rd_addr;
  logic                    wgt_rd_en;
  logic [ADDR_WIDTH-1:0]   wgt_rd_addr;

  logic                    pe_enable;
  logic                    pe_clear_acc;
  logic [2*DATA_WIDTH-1:0] pe_acc_in;

  logic                    res_valid;
  logic                    res_ready;
  logic [DATA_WIDTH-1:0]   res_data;
  logic                    res_sat;

  logic                    busy;

  modport master (
    input  cmd_valid, cmd_len, cmd_act_base, cmd_wgt_base, pe_acc_in, res_ready,
    output cmd_ready, act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr,
           pe_enable, pe_clear_acc, res_valid, res_data, res_sat, busy
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_act_base, cmd_wgt_base, pe_acc_in, res_ready,
    input  cmd_ready, act_rd_en, act_rd_addr, wgt_rd_en, wgt_rd_addr,
           pe_enable, pe_clear_acc, res_valid, res_data, res_sat, busy
  );

endinterface

// File: rtl/pe_mac_sequencer_q_round_sat.sv
// ---------------------------------------------------------------------------
// pe_mac_sequencer_q_round_sat
//   Combinational Q(2F) -> Q(F) conversion of the PE accumulator:
//   round half up, arithmetic shift, saturate to the signed result range.
//   acc_in   : signed accumulator, 2*DATA_WIDTH bits
//   res_data : signed result, DATA_WIDTH bits
//   res_sat  : 1 when the value was clipped to the max/min code
// ---------------------------------------------------------------------------
module pe_mac_sequencer_q_round_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic [2*DATA_WIDTH-1:0] acc_in,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic                    res_sat
);

  // One extra bit so adding the rounding constant can never overflow.
  localparam int EXT_W = 2*DATA_WIDTH + 1;

  localparam logic signed [EXT_W-1:0] HALF_LSB =
    {{(EXT_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] SAT_HI =
    {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_LO =
    {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [DATA_WIDTH-1:0] CODE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] CODE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [EXT_W-1:0] acc_ext;
  logic signed [EXT_W-1:0] rounded;
  logic signed [EXT_W-1:0] shifted;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned infers a latch.
  always_comb begin
    acc_ext  = {acc_in[2*DATA_WIDTH-1], acc_in};
    rounded  = acc_ext + HALF_LSB;
    shifted  = rounded >>> FRAC_BITS;
    res_data = shifted[DATA_WIDTH-1:0];
    res_sat  = 1'b0;
    if (shifted > SAT_HI) begin
      res_data = CODE_MAX;
      res_sat  = 1'b1;
    end else if (shifted < SAT_LO) begin
      res_data = CODE_MIN;
      res_sat  = 1'b1;
    end
  end

endmodule

// File: rtl/pe_mac_sequencer.sv
// ---------------------------------------------------------------------------
// pe_mac_sequencer
//   Drives one MAC PE through a length-L dot product:
//   IDLE -> CLEAR -> RUN (L cycles) -> DRAIN (3 cycles) -> OUT -> IDLE.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (aborts any operation in flight)
//   bus  : pe_mac_sequencer_if.master -- command, buffer reads, PE control,
//          result and busy (see the interface for the signal list)
//   Buffer read data returns one cycle after a read strobe and feeds the PE
//   directly, so pe_enable is the read strobe delayed by one register.
// ---------------------------------------------------------------------------
module pe_mac_sequencer
  import pe_mac_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  pe_mac_sequencer_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]   LEN_ONE    = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = {{(DRAIN_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    run_cnt_q;     // products still to fetch
  logic [ADDR_WIDTH-1:0]   act_addr_q;
  logic [ADDR_WIDTH-1:0]   wgt_addr_q;
  logic [DRAIN_CNT_W-1:0]  drain_cnt_q;
  logic                    pe_en_q;
  logic [DATA_WIDTH-1:0]   res_data_q;
  logic                    res_sat_q;

  logic                    load_cmd;
  logic                    rd_en;
  logic                    drain_step;
  logic                    capture;
  logic                    cmd_ready;
  logic                    clear_acc;
  logic                    res_valid;

  logic [DATA_WIDTH-1:0]   conv_data;
  logic                    conv_sat;

  pe_mac_sequencer_q_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_round_sat (
    .acc_in   (bus.pe_acc_in),
    .res_data (conv_data),
    .res_sat  (conv_sat)
  );

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and control decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    load_cmd   = 1'b0;
    rd_en      = 1'b0;
    drain_step = 1'b0;
    capture    = 1'b0;
    cmd_ready  = 1'b0;
    clear_acc  = 1'b0;
    res_valid  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          load_cmd = 1'b1;
          state_d  = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        clear_acc = 1'b1;
        state_d   = (run_cnt_q != '0) ? ST_RUN : ST_DRAIN;
      end

      ST_RUN: begin
        rd_en = 1'b1;
        if (run_cnt_q == LEN_ONE) begin
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        drain_step = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end
      end

      ST_OUT: begin
        res_valid = 1'b1;
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers: counters, addresses, PE enable delay, result
  // -------------------------------------------------------------------------
  // NOTE: only the sequencer's own registers are reset; the PE accumulator is
  // left alone because every command starts with a CLEAR cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q   <= '0;
      act_addr_q  <= '0;
      wgt_addr_q  <= '0;
      drain_cnt_q <= '0;
      pe_en_q     <= 1'b0;
      res_data_q  <= '0;
      res_sat_q   <= 1'b0;
    end else begin
      // Read data lands one cycle after the strobe; the PE consumes it then.
      // CLEAR is always preceded by IDLE, so this never overlaps a clear.
      pe_en_q <= rd_en;

      if (load_cmd) begin
        run_cnt_q  <= bus.cmd_len;
        act_addr_q <= bus.cmd_act_base;
        wgt_addr_q <= bus.cmd_wgt_base;
      end else if (rd_en) begin
        // Address arithmetic wraps modulo the buffer size by width.
        run_cnt_q  <= run_cnt_q - LEN_ONE;
        act_addr_q <= act_addr_q + ADDR_ONE;
        wgt_addr_q <= wgt_addr_q + ADDR_ONE;
      end

      drain_cnt_q <= drain_step ? (drain_cnt_q + DRAIN_ONE) : '0;

      if (capture) begin
        res_data_q <= conv_data;
        res_sat_q  <= conv_sat;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.cmd_ready    = cmd_ready;
  assign bus.act_rd_en    = rd_en;
  assign bus.act_rd_addr  = act_addr_q;
  assign bus.wgt_rd_en    = rd_en;
  assign bus.wgt_rd_addr  = wgt_addr_q;
  assign bus.pe_enable    = pe_en_q;
  assign bus.pe_clear_acc = clear_acc;
  assign bus.res_valid    = res_valid;
  assign bus.res_data     = res_data_q;
  assign bus.res_sat      = res_sat_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pe_mac_sequencer
//   Self-checking bench for pe_mac_sequencer. Models the two operand buffers
//   (one-cycle read latency) and a PE with a product register in front of
//   the accumulator. Expected results come from a dot-product reference
//   computed with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_pe_mac_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pe_mac_sequencer_if bus ();

  pe_mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- environment model: buffers + PE ----------------
  logic [15:0]        act_mem [256];
  logic [15:0]        wgt_mem [256];
  logic [15:0]        act_rd_q = '0;
  logic [15:0]        wgt_rd_q = '0;
  logic signed [31:0] prod_q   = '0;
  logic               prod_v   = 1'b0;
  logic signed [31:0] pe_acc   = '0;
  logic               force_en;
  logic [31:0]        force_val;

  always @(posedge clk) begin
    if (bus.act_rd_en) act_rd_q <= act_mem[bus.act_rd_addr];
    if (bus.wgt_rd_en) wgt_rd_q <= wgt_mem[bus.wgt_rd_addr];
    prod_v <= bus.pe_enable;
    if (bus.pe_enable) prod_q <= $signed(act_rd_q) * $signed(wgt_rd_q);
    if (bus.pe_clear_acc) pe_acc <= '0;
    else if (prod_v)      pe_acc <= pe_acc + prod_q;
  end

  assign bus.pe_acc_in = force_en ? force_val : pe_acc;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;

  int         n_rd, n_pe_en, n_clear;
  logic [7:0] act_addrs [$];
  logic [7:0] wgt_addrs [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Activity monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.act_rd_en === 1'b1) begin
        n_rd++;
        act_addrs.push_back(bus.act_rd_addr);
        wgt_addrs.push_back(bus.wgt_rd_addr);
      end
      if (bus.pe_enable === 1'b1) n_pe_en++;
      if (bus.pe_clear_acc === 1'b1) begin
        n_clear++;
        check("clear_vs_enable", {31'd0, bus.pe_enable}, 32'd0);
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [16:0] q_convert(input logic [31:0] acc);
    longint s;
    s = longint'($signed(acc));
    s = s + 128;
    s = s >>> 8;
    if (s > 32767)  return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, s[15:0]};
  endfunction

  function automatic logic [16:0] ref_result(input int len, input logic [7:0] ab, input logic [7:0] wb);
    longint      sum;
    logic [31:0] acc32;
    sum = 0;
    for (int i = 0; i < len; i++) begin
      sum += longint'($signed(act_mem[(int'(ab) + i) % 256])) *
             longint'($signed(wgt_mem[(int'(wb) + i) % 256]));
    end
    acc32 = sum[31:0];  // the PE accumulator is 32 bits wide and wraps
    return q_convert(acc32);
  endfunction

  // ---------------- one full command ----------------
  // Called one tick after a rising edge with the sequencer idle. Keeps
  // cmd_valid high with junk fields while busy to show they are ignored.
  task automatic run_cmd(input int len, input logic [7:0] ab, input logic [7:0] wb,
                         input int hold, input logic [15:0] exp_d, input logic exp_s,
                         input string tag);
    int lat;
    n_rd = 0; n_pe_en = 0; n_clear = 0;
    act_addrs.delete(); wgt_addrs.delete();
    check({tag, "_ready_before"}, {31'd0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid    = 1'b1;
    bus.cmd_len      = 8'(len);
    bus.cmd_act_base = ab;
    bus.cmd_wgt_base = wb;
    @(posedge clk); #1;
    bus.cmd_len      = 8'($urandom);
    bus.cmd_act_base = 8'($urandom);
    bus.cmd_wgt_base = 8'($urandom);
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.cmd_valid = 1'b0;
    check({tag, "_latency"}, lat, len + 5);
    for (int h = 0; h < hold; h++) begin
      check({tag, "_hold_valid"}, {31'd0, bus.res_valid}, 32'd1);
      check({tag, "_hold_data"}, {16'd0, bus.res_data}, {16'd0, exp_d});
      check({tag, "_hold_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check({tag, "_data"}, {16'd0, bus.res_data}, {16'd0, exp_d});
    check({tag, "_sat"}, {31'd0, bus.res_sat}, {31'd0, exp_s});
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'd0, bus.res_valid}, 32'd0);
    check({tag, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_n_rd"}, n_rd, len);
    check({tag, "_n_pe_en"}, n_pe_en, len);
    check({tag, "_n_clear"}, n_clear, 1);
    for (int i = 0; i < act_addrs.size(); i++) begin
      check($sformatf("%s_act_addr%0d", tag, i), {24'd0, act_addrs[i]}, {24'd0, 8'(ab + 8'(i))});
      check($sformatf("%s_wgt_addr%0d", tag, i), {24'd0, wgt_addrs[i]}, {24'd0, 8'(wb + 8'(i))});
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic [16:0] r;
  bit          saw_valid;

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_len      = '0;
    bus.cmd_act_base = '0;
    bus.cmd_wgt_base = '0;
    bus.res_ready    = 1'b0;
    force_en         = 1'b0;
    force_val        = '0;
    for (int j = 0; j < 256; j++) begin
      act_mem[j] = '0;
      wgt_mem[j] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rd_en", {30'd0, bus.act_rd_en, bus.wgt_rd_en}, 32'd0);
    check("rst_pe", {30'd0, bus.pe_enable, bus.pe_clear_acc}, 32'd0);
    check("rst_res", {15'd0, bus.res_valid, bus.res_sat, bus.res_data}, 32'd0);
    check("rst_addr", {16'd0, bus.act_rd_addr, bus.wgt_rd_addr}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 1 + 2 - 0.5 + 0.25 = 2.75
    act_mem[0] = 16'h0100; act_mem[1] = 16'h0200;
    act_mem[2] = 16'hFF80; act_mem[3] = 16'h0040;
    for (int j = 0; j < 4; j++) wgt_mem[8'h80 + j] = 16'h0100;
    run_cmd(4, 8'h00, 8'h80, 0, 16'h02C0, 1'b0, "t1");

    // 2: positive and negative saturation
    act_mem[8'h20] = 16'h7F00; act_mem[8'h21] = 16'h7F00;
    wgt_mem[8'h20] = 16'h7F00; wgt_mem[8'h21] = 16'h7F00;
    run_cmd(2, 8'h20, 8'h20, 1, 16'h7FFF, 1'b1, "t2_pos");
    act_mem[8'h30] = 16'h8100; act_mem[8'h31] = 16'h8100;
    wgt_mem[8'h30] = 16'h7F00; wgt_mem[8'h31] = 16'h7F00;
    run_cmd(2, 8'h30, 8'h30, 2, 16'h8000, 1'b1, "t2_neg");

    // 3: rounding on a forced accumulator value
    force_en = 1'b1;
    force_val = 32'h0000_0080;
    run_cmd(0, 8'h00, 8'h00, 0, 16'h0001, 1'b0, "t3_half_up");
    force_val = 32'hFFFF_FF80;
    run_cmd(0, 8'h00, 8'h00, 0, 16'h0000, 1'b0, "t3_neg_half");
    force_val = 32'hFFFF_FF7F;
    run_cmd(0, 8'h00, 8'h00, 0, 16'hFFFF, 1'b0, "t3_below_half");
    force_en = 1'b0;

    // 4: zero length
    run_cmd(0, 8'h55, 8'hAA, 0, 16'h0000, 1'b0, "t4_len0");

    // 5: address wrap plus a long back-pressure hold
    act_mem[8'hFE] = 16'h0100; act_mem[8'hFF] = 16'h0080;
    act_mem[8'h00] = 16'hFF00; act_mem[8'h01] = 16'h0300;
    for (int j = 0; j < 4; j++) wgt_mem[8'h10 + j] = 16'h0200;
    r = ref_result(4, 8'hFE, 8'h10);
    run_cmd(4, 8'hFE, 8'h10, 10, r[15:0], r[16], "t5");
    check("t5_addr_seq0", {24'd0, act_addrs[0]}, 32'h0000_00FE);
    check("t5_addr_seq1", {24'd0, act_addrs[1]}, 32'h0000_00FF);
    check("t5_addr_seq2", {24'd0, act_addrs[2]}, 32'h0000_0000);
    check("t5_addr_seq3", {24'd0, act_addrs[3]}, 32'h0000_0001);

    // 6: reset during RUN, then a short command over a stale accumulator
    for (int j = 0; j < 8; j++) begin
      act_mem[8'h60 + j] = 16'h0300;
      wgt_mem[8'h60 + j] = 16'h0500;
    end
    bus.cmd_valid    = 1'b1;
    bus.cmd_len      = 8'd8;
    bus.cmd_act_base = 8'h60;
    bus.cmd_wgt_base = 8'h60;
    @(posedge clk); #1;          // CLEAR
    bus.cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end  // RUN cycle index 2
    check("t6_in_run", {31'd0, bus.act_rd_en}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_rst_rd_en", {30'd0, bus.act_rd_en, bus.wgt_rd_en}, 32'd0);
    check("t6_rst_pe", {30'd0, bus.pe_enable, bus.pe_clear_acc}, 32'd0);
    check("t6_rst_res", {15'd0, bus.res_valid, bus.res_sat, bus.res_data}, 32'd0);
    check("t6_rst_addr", {16'd0, bus.act_rd_addr, bus.wgt_rd_addr}, 32'd0);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.res_valid === 1'b1) saw_valid = 1'b1;
    end
    check("t6_no_result", {31'd0, saw_valid}, 32'd0);
    act_mem[8'h40] = 16'h0100;
    wgt_mem[8'h40] = 16'h0100;
    run_cmd(1, 8'h40, 8'h40, 0, 16'h0100, 1'b0, "t6_after");

    // Randomized commands against the reference model
    for (int k = 0; k < 24; k++) begin
      int         len;
      logic [7:0] ab, wb;
      bit         wide;
      wide = 1'($urandom_range(0, 1));
      for (int j = 0; j < 256; j++) begin
        act_mem[j] = wide ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
        wgt_mem[j] = wide ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
      end
      len = (k % 6 == 5) ? int'($urandom_range(100, 255)) : int'($urandom_range(0, 12));
      ab  = 8'($urandom);
      wb  = 8'($urandom);
      r   = ref_result(len, ab, wb);
      run_cmd(len, ab, wb, int'($urandom_range(0, 3)), r[15:0], r[16], $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
